pll_lock_rst_seq: RTL and testbench

//  Sits directly downstream of the clocking-wizard PLL wrapper. Consumes the raw PLL
//  'locked' status and qualifies it. Drives the PLL's reset input. Releases the

---
 rtl/pll_lock_rst_seq_pkg.sv | 29 ++
 rtl/pll_lock_rst_seq_cdc_sync.sv | 31 +++
 rtl/pll_lock_rst_seq.sv | 154 +++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_rst_seq_pkg
//  Description : Shared types and helpers for the PLL lock / reset sequencer.
//                Holds the FSM state encoding and the saturating-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package pll_lock_rst_seq_pkg;

    // Sequencer states; the encoding is fixed so it can be observed externally.
    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // Width of the lock-loss and retry event counters.
    localparam int SAT_W = 8;
    localparam logic [SAT_W-1:0] SAT_MAX = '1;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val);
        return (val == SAT_MAX) ? val : val + SAT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_rst_seq_cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_sync_bit
//  Description : Multi-flop single-bit synchronizer with synchronous reset to 0.
//                Latency from d to q is STAGES clock cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_rst_seq
//  Description : Qualifies the PLL locked flag, pulses the PLL reset, and
//                releases block resets in a staggered order once lock is
//                stable. Lock loss or lock timeout restarts the whole sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module pll_lock_rst_seq
    import pll_lock_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int NUM_RST          = 4,
    parameter int STAGGER_CYC      = 16,
    parameter int CNT_W            = 17
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               pll_locked,
    output logic               pll_reset,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic [SAT_W-1:0]   lock_loss_cnt,
    output logic [SAT_W-1:0]   retry_cnt
);

    // Terminal counter values for each timed state.
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The edge that enters S_STABLE has already seen one locked cycle, so the
    // stable window ends one count earlier than LOCK_STABLE_CYC-1.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYC > 1) ? (LOCK_STABLE_CYC - 2) : 0);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'((NUM_RST - 1) * STAGGER_CYC);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lock_s;
    logic             timeout_evt;
    logic             loss_evt;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // Next-state, next-counter and event decode.
    always_comb begin
        state_d     = state_q;
        timeout_evt = 1'b0;
        loss_evt    = 1'b0;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == PLLRST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = S_PLLRST;
                    timeout_evt = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    state_d  = S_PLLRST;
                    loss_evt = 1'b1;
                end else if (cnt_q == RELEASE_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d  = S_PLLRST;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase

        // Counter restarts on every state change and idles at zero in S_RUN.
        if ((state_d != state_q) || (state_q == S_RUN)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, counter and next-state-decoded status outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            pll_reset <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pll_reset <= (state_d == S_PLLRST);
            ready     <= (state_d == S_RUN);
        end
    end

    // One sticky register per block reset; bit i drops when the release
    // counter lands on i*STAGGER_CYC and all bits re-assert together.
    for (genvar i = 0; i < NUM_RST; i++) begin : g_rst
        localparam logic [CNT_W-1:0] REL_AT = CNT_W'(i * STAGGER_CYC);
        logic bit_q;

        // Per-bit reset release register.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                bit_q <= 1'b1;
            end else begin
                case (state_d)
                    S_RELEASE: if (cnt_d == REL_AT) bit_q <= 1'b0;
                    S_RUN:     bit_q <= 1'b0;
                    default:   bit_q <= 1'b1;
                endcase
            end
        end

        assign rst_out[i] = bit_q;
    end

    // Saturating lock-loss and lock-timeout event counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_loss_cnt <= '0;
            retry_cnt     <= '0;
        end else begin
            if (loss_evt)    lock_loss_cnt <= sat_inc(lock_loss_cnt);
            if (timeout_evt) retry_cnt     <= sat_inc(retry_cnt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_rst_seq
//  Description : Self-checking bench for pll_lock_rst_seq. Each scenario
//                queues expected output snapshots at absolute cycle numbers
//                and compares them as the run reaches those cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pll_lock_rst_seq;

    localparam int NUM_RST = 3;
    localparam int BUDGET  = 20000;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               pll_locked;
    logic               pll_reset;
    logic [NUM_RST-1:0] rst_out;
    logic               ready;
    logic [7:0]         lock_loss_cnt;
    logic [7:0]         retry_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          at;
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    pll_lock_rst_seq #(
        .SYNC_STAGES      (2),
        .PLL_RST_CYC      (4),
        .LOCK_TIMEOUT_CYC (64),
        .LOCK_STABLE_CYC  (8),
        .NUM_RST          (NUM_RST),
        .STAGGER_CYC      (3),
        .CNT_W            (17)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .pll_locked    (pll_locked),
        .pll_reset     (pll_reset),
        .rst_out       (rst_out),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .retry_cnt     (retry_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [20:0] mk(input logic pr, input logic rdy,
                                       input logic [2:0] rst, input int ll, input int rc);
        return {pr, rdy, rst, 8'(ll), 8'(rc)};
    endfunction

    function automatic logic [20:0] snap();
        return {pll_reset, ready, rst_out, lock_loss_cnt, retry_cnt};
    endfunction

    function automatic string fmt(input logic [20:0] v);
        return $sformatf("pr=%b rdy=%b rst=%b ll=%0d rc=%0d",
                         v[20], v[19], v[18:16], v[15:8], v[7:0]);
    endfunction

    task automatic push_exp(input int at, input logic [20:0] v, input string tag);
        exp_t e;
        e.at  = at;
        e.v   = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // Holds sys_rst for two edges; sys_rst is still high on return.
    task automatic do_reset(input logic locked);
        sys_rst    = 1'b1;
        pll_locked = locked;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [20:0] want;
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        want = mk(1, 0, 3'b111, 0, 0);
        checks++;
        if (snap() !== want) begin
            failures++;
            $display("FAIL reset_values cyc=%0d got %s exp %s", cyc, fmt(snap()), fmt(want));
        end
    endtask

    task automatic test_nominal();
        int   t0;
        exp_t e;
        do_reset(1'b0);
        t0 = cyc;
        sys_rst = 1'b0;
        push_exp(t0 + 3,  mk(1, 0, 3'b111, 0, 0), "nom_pllrst_hold");
        push_exp(t0 + 4,  mk(0, 0, 3'b111, 0, 0), "nom_pllrst_fall");
        push_exp(t0 + 23, mk(0, 0, 3'b111, 0, 0), "nom_pre_release");
        push_exp(t0 + 24, mk(0, 0, 3'b110, 0, 0), "nom_rel0");
        push_exp(t0 + 26, mk(0, 0, 3'b110, 0, 0), "nom_rel0_hold");
        push_exp(t0 + 27, mk(0, 0, 3'b100, 0, 0), "nom_rel1");
        push_exp(t0 + 30, mk(0, 0, 3'b000, 0, 0), "nom_rel2");
        push_exp(t0 + 31, mk(0, 1, 3'b000, 0, 0), "nom_ready");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc == t0 + 14) pll_locked = 1'b1;
            if (cyc > t0 + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL nom_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_lock_timeout();
        int   t0;
        exp_t e;
        do_reset(1'b0);
        t0 = cyc;
        sys_rst = 1'b0;
        push_exp(t0 + 4,   mk(0, 0, 3'b111, 0, 0), "to_wait");
        push_exp(t0 + 67,  mk(0, 0, 3'b111, 0, 0), "to_before1");
        push_exp(t0 + 68,  mk(1, 0, 3'b111, 0, 1), "to_retry1");
        push_exp(t0 + 71,  mk(1, 0, 3'b111, 0, 1), "to_pulse_end");
        push_exp(t0 + 72,  mk(0, 0, 3'b111, 0, 1), "to_pulse_fall");
        push_exp(t0 + 135, mk(0, 0, 3'b111, 0, 1), "to_before2");
        push_exp(t0 + 136, mk(1, 0, 3'b111, 0, 2), "to_retry2");
        push_exp(t0 + 204, mk(1, 0, 3'b111, 0, 3), "to_retry3");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc > t0 + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL to_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_unstable_lock();
        int   t0;
        int   l;
        exp_t e;
        do_reset(1'b0);
        t0 = cyc;
        l  = t0 + 10;
        sys_rst = 1'b0;
        push_exp(l + 7,  mk(0, 0, 3'b111, 0, 0), "ul_glitch_stable");
        push_exp(l + 8,  mk(0, 0, 3'b111, 0, 0), "ul_glitch_drop");
        push_exp(l + 15, mk(0, 0, 3'b111, 0, 0), "ul_no_early_release");
        push_exp(l + 16, mk(0, 0, 3'b110, 0, 0), "ul_rel0");
        push_exp(l + 22, mk(0, 0, 3'b000, 0, 0), "ul_rel2");
        push_exp(l + 23, mk(0, 1, 3'b000, 0, 0), "ul_ready");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc == l)     pll_locked = 1'b1;
            if (cyc == l + 5) pll_locked = 1'b0;
            if (cyc == l + 6) pll_locked = 1'b1;
            if (cyc > t0 + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL ul_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // Entered with the DUT in S_RUN and no prior lock loss.
    task automatic test_lock_loss_run();
        int   t;
        exp_t e;
        t = cyc;
        pll_locked = 1'b0;
        push_exp(t + 2,  mk(0, 1, 3'b000, 0, 0), "llr_still_run");
        push_exp(t + 3,  mk(1, 0, 3'b111, 1, 0), "llr_loss");
        push_exp(t + 6,  mk(1, 0, 3'b111, 1, 0), "llr_pllrst");
        push_exp(t + 7,  mk(0, 0, 3'b111, 1, 0), "llr_wait");
        push_exp(t + 19, mk(0, 0, 3'b111, 1, 0), "llr_pre_release");
        push_exp(t + 20, mk(0, 0, 3'b110, 1, 0), "llr_rel0");
        push_exp(t + 27, mk(0, 1, 3'b000, 1, 0), "llr_recovered");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc == t + 10) pll_locked = 1'b1;
            if (cyc > t + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL llr_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // Entered in S_RUN with lock_loss_cnt=1; leaves the DUT in S_RUN again.
    task automatic test_lock_loss_mid_release();
        int   t;
        exp_t e;
        t = cyc;
        pll_locked = 1'b0;
        push_exp(t + 3,  mk(1, 0, 3'b111, 2, 0), "llm_loss_run");
        push_exp(t + 18, mk(0, 0, 3'b110, 2, 0), "llm_rel0");
        push_exp(t + 21, mk(0, 0, 3'b100, 2, 0), "llm_rel1");
        push_exp(t + 23, mk(0, 0, 3'b100, 2, 0), "llm_hold");
        push_exp(t + 24, mk(1, 0, 3'b111, 3, 0), "llm_reassert");
        push_exp(t + 36, mk(0, 0, 3'b110, 3, 0), "llm_re_rel0");
        push_exp(t + 43, mk(0, 1, 3'b000, 3, 0), "llm_recovered");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc == t + 8)  pll_locked = 1'b1;
            if (cyc == t + 21) pll_locked = 1'b0;
            if (cyc == t + 24) pll_locked = 1'b1;
            if (cyc > t + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL llm_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // Entered in S_RUN with lock_loss_cnt=3 and pll_locked held high.
    task automatic test_sysrst_mid_run();
        int   t;
        exp_t e;
        t = cyc;
        sys_rst = 1'b1;
        push_exp(t + 1,  mk(1, 0, 3'b111, 0, 0), "srst_immediate");
        push_exp(t + 2,  mk(1, 0, 3'b111, 0, 0), "srst_held");
        push_exp(t + 6,  mk(0, 0, 3'b111, 0, 0), "srst_wait");
        push_exp(t + 13, mk(0, 0, 3'b111, 0, 0), "srst_pre_release");
        push_exp(t + 14, mk(0, 0, 3'b110, 0, 0), "srst_rel0");
        push_exp(t + 21, mk(0, 1, 3'b000, 0, 0), "srst_ready");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc == t + 2) sys_rst = 1'b0;
            if (cyc > t + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL srst_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_saturation();
        int   t0;
        exp_t e;
        do_reset(1'b0);
        t0 = cyc;
        sys_rst = 1'b0;
        push_exp(t0 + 68 * 254,     mk(1, 0, 3'b111, 0, 254), "sat_254");
        push_exp(t0 + 68 * 255,     mk(1, 0, 3'b111, 0, 255), "sat_255");
        push_exp(t0 + 68 * 256,     mk(1, 0, 3'b111, 0, 255), "sat_no_wrap");
        push_exp(t0 + 68 * 260,     mk(1, 0, 3'b111, 0, 255), "sat_260");
        push_exp(t0 + 68 * 260 + 4, mk(0, 0, 3'b111, 0, 255), "sat_still_retrying");
        while (exp_q.size() > 0) begin
            tick();
            while (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (snap() !== e.v) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got %s exp %s", e.tag, cyc, fmt(snap()), fmt(e.v));
                end
            end
            if (cyc > t0 + BUDGET) begin
                checks++;
                failures++;
                $display("FAIL sat_budget cyc=%0d pending=%0d", cyc, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    // Scenario sequence; later scenarios rely on the state left by earlier ones.
    initial begin
        sys_rst    = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_nominal();
        test_lock_timeout();
        test_unstable_lock();
        test_lock_loss_run();
        test_lock_loss_mid_release();
        test_sysrst_mid_run();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
